// File: rtl/hpu_pkg.sv
// Shared HPU definitions: DTCM line geometry and the write-pack line slot.
package hpu_pkg;

    localparam int LINE_W          = 256;
    localparam int LINE_WORDS      = 8;
    localparam int PACK_FLUSH_TMO  = 16;
    localparam int DTCM_LINE_IDX_W = 9;

    typedef struct packed {
        logic                       vld;
        logic [DTCM_LINE_IDX_W-1:0] line;
        logic [LINE_W-1:0]          data;
        logic [LINE_WORDS-1:0]      strb;
    } dtcm_line_slot_t;

endpackage

// File: rtl/hpu_dtcm_line_merge.sv
// Inserts one 32-bit word into a line image and flags when every word is present.
module hpu_dtcm_line_merge
    import hpu_pkg::*;
(
    input  logic [LINE_W-1:0]     i_data,
    input  logic [LINE_WORDS-1:0] i_strb,
    input  logic [2:0]            i_idx,
    input  logic [31:0]           i_word,
    output logic [LINE_W-1:0]     o_data,
    output logic [LINE_WORDS-1:0] o_strb,
    output logic                  o_full
);

    always_comb begin
        o_data              = i_data;
        o_data[i_idx*32 +: 32] = i_word;
        o_strb              = i_strb;
        o_strb[i_idx]       = 1'b1;
        o_full              = &o_strb;
    end

endmodule

// File: rtl/hpu_dtcm_wr_pack.sv
// Coalesces 32-bit NDMA write beats into full DTCM line writes through a
// fill/pending slot pair; line writes wait out the DTCM atomic bus lock.
module hpu_dtcm_wr_pack
    import hpu_pkg::*;
#(
    parameter int FLUSH_TMO = PACK_FLUSH_TMO,
    parameter int ADDR_W    = 14
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ndma_pack__beat_vld_i,
    input  logic [ADDR_W-1:0]     ndma_pack__beat_addr_i,
    input  logic [31:0]           ndma_pack__beat_data_i,
    input  logic                  ndma_pack__beat_last_i,
    output logic                  pack_ndma__beat_rdy_o,
    output logic                  pack_dtcm__mem_we_o,
    output logic [ADDR_W-1:0]     pack_dtcm__mem_waddr_o,
    output logic [LINE_W-1:0]     pack_dtcm__mem_wdata_o,
    output logic [LINE_WORDS-1:0] pack_dtcm__mem_wstrb_o,
    input  logic                  dtcm_pack__mem_atom_ready_i,
    output logic                  pack_ndma__idle_o
);

    localparam int CNT_W = (FLUSH_TMO > 2) ? $clog2(FLUSH_TMO) : 1;

    dtcm_line_slot_t r_fill;
    dtcm_line_slot_t r_pend;
    logic            r_fill_seal;
    logic [CNT_W-1:0] r_cnt;

    logic [DTCM_LINE_IDX_W-1:0] w_beat_line;
    logic [2:0]                 w_beat_idx;
    logic                       w_issue;
    logic                       w_pend_free;
    logic                       w_mismatch;
    logic                       w_acc;
    logic [LINE_W-1:0]          w_base_data;
    logic [LINE_WORDS-1:0]      w_base_strb;
    logic [LINE_W-1:0]          w_mrg_data;
    logic [LINE_WORDS-1:0]      w_mrg_strb;
    logic                       w_mrg_full;
    logic                       w_new_seal;
    logic                       w_tmo;
    logic                       w_prom_old;
    logic                       w_prom_new;
    dtcm_line_slot_t            w_new_slot;
    logic                       w_unused_addr;

    assign w_beat_line   = DTCM_LINE_IDX_W'(ndma_pack__beat_addr_i[ADDR_W-1:5]);
    assign w_beat_idx    = ndma_pack__beat_addr_i[4:2];
    assign w_unused_addr = &{1'b0, ndma_pack__beat_addr_i[1:0]};

    assign w_issue     = r_pend.vld & dtcm_pack__mem_atom_ready_i;
    assign w_pend_free = !r_pend.vld | w_issue;
    assign w_mismatch  = r_fill.vld & (r_fill_seal | (w_beat_line != r_fill.line));

    assign pack_ndma__beat_rdy_o = !(w_mismatch & !w_pend_free);
    assign w_acc                 = ndma_pack__beat_vld_i & pack_ndma__beat_rdy_o;

    // A beat that does not merge starts a fresh line image from all-zero.
    assign w_base_data = (r_fill.vld & !w_mismatch) ? r_fill.data : '0;
    assign w_base_strb = (r_fill.vld & !w_mismatch) ? r_fill.strb : '0;

    hpu_dtcm_line_merge u_merge (
        .i_data (w_base_data),
        .i_strb (w_base_strb),
        .i_idx  (w_beat_idx),
        .i_word (ndma_pack__beat_data_i),
        .o_data (w_mrg_data),
        .o_strb (w_mrg_strb),
        .o_full (w_mrg_full)
    );

    assign w_new_seal = w_mrg_full | ndma_pack__beat_last_i;
    assign w_new_slot = '{vld: 1'b1, line: w_beat_line, data: w_mrg_data, strb: w_mrg_strb};

    assign w_tmo = (FLUSH_TMO != 0) && r_fill.vld && !r_fill_seal && !w_acc &&
                   (int'(r_cnt) + 1 >= FLUSH_TMO - 1);

    // Old fill leaves on a mismatching beat or once sealed; a line that seals on
    // its own beat skips the fill slot when pending can take it.
    assign w_prom_old = r_fill.vld & w_pend_free & (w_acc ? w_mismatch : (r_fill_seal | w_tmo));
    assign w_prom_new = w_acc & !w_mismatch & w_new_seal & w_pend_free;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_fill      <= '0;
            r_pend      <= '0;
            r_fill_seal <= 1'b0;
            r_cnt       <= '0;
        end else begin
            if (w_prom_old)
                r_pend <= r_fill;
            else if (w_prom_new)
                r_pend <= w_new_slot;
            else if (w_issue)
                r_pend.vld <= 1'b0;

            if (w_acc) begin
                if (w_prom_new) begin
                    r_fill.vld  <= 1'b0;
                    r_fill_seal <= 1'b0;
                end else begin
                    r_fill      <= w_new_slot;
                    r_fill_seal <= w_new_seal;
                end
            end else if (w_prom_old) begin
                r_fill.vld  <= 1'b0;
                r_fill_seal <= 1'b0;
            end else if (w_tmo) begin
                r_fill_seal <= 1'b1;
            end

            if (w_acc || !r_fill.vld)
                r_cnt <= '0;
            else if (!r_fill_seal)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign pack_dtcm__mem_we_o    = w_issue;
    assign pack_dtcm__mem_waddr_o = ADDR_W'({r_pend.line, 5'b0});
    assign pack_dtcm__mem_wdata_o = r_pend.data;
    assign pack_dtcm__mem_wstrb_o = r_pend.strb;
    assign pack_ndma__idle_o      = !r_fill.vld & !r_pend.vld;

endmodule

// File: tb/tb_hpu_dtcm_wr_pack.sv
// Scoreboard bench for hpu_dtcm_wr_pack: a line-grouping reference model
// queues expected writes, a monitor checks every mem_we against them.
module tb_hpu_dtcm_wr_pack;

    localparam int TMO = 16;
    localparam int AW  = 14;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vld;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic          last;
    logic          rdy;
    logic          we;
    logic [AW-1:0] waddr;
    logic [255:0]  wdata;
    logic [7:0]    wstrb;
    logic          atom;
    logic          idle;

    hpu_dtcm_wr_pack #(.FLUSH_TMO(TMO), .ADDR_W(AW)) dut (
        .clk_i                       (clk),
        .rst_i                       (rst_n),
        .ndma_pack__beat_vld_i       (vld),
        .ndma_pack__beat_addr_i      (addr),
        .ndma_pack__beat_data_i      (data),
        .ndma_pack__beat_last_i      (last),
        .pack_ndma__beat_rdy_o       (rdy),
        .pack_dtcm__mem_we_o         (we),
        .pack_dtcm__mem_waddr_o      (waddr),
        .pack_dtcm__mem_wdata_o      (wdata),
        .pack_dtcm__mem_wstrb_o      (wstrb),
        .dtcm_pack__mem_atom_ready_i (atom),
        .pack_ndma__idle_o           (idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [255:0]  data;
        logic [7:0]    strb;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;
    int  we_cnt = 0;
    bit  rand_mode = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: beats group into lines; a group ends on a line change,
    // all eight words present, a last beat, or TMO-1 idle cycles after a beat.
    logic       m_open = 1'b0;
    logic [8:0] m_line;
    logic [31:0] m_w[8];
    logic [7:0] m_strb;
    int         m_idle = 0;

    function automatic wr_t m_group();
        wr_t g;
        g.addr = {m_line, 5'b0};
        g.data = '0;
        for (int i = 0; i < 8; i++) g.data[i*32 +: 32] = m_w[i];
        g.strb = m_strb;
        return g;
    endfunction

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            m_open = 1'b0;
            m_idle = 0;
        end else if (vld && rdy) begin
            if (m_open && addr[13:5] != m_line) begin
                exp_q.push_back(m_group());
                m_open = 1'b0;
            end
            if (!m_open) begin
                m_open = 1'b1;
                m_line = addr[13:5];
                m_strb = '0;
                for (int i = 0; i < 8; i++) m_w[i] = '0;
            end
            m_w[addr[4:2]]    = data;
            m_strb[addr[4:2]] = 1'b1;
            if (last || m_strb == 8'hFF) begin
                exp_q.push_back(m_group());
                m_open = 1'b0;
            end
            m_idle = 0;
        end else if (m_open) begin
            m_idle++;
            if (TMO != 0 && m_idle == TMO - 1) begin
                exp_q.push_back(m_group());
                m_open = 1'b0;
            end
        end
    end

    initial forever begin
        wr_t e;
        @(negedge clk);
        if (rst_n && we) begin
            we_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got addr=%h strb=%h, expected no write", waddr, wstrb);
            end else begin
                e = exp_q.pop_front();
                if (waddr !== e.addr || wstrb !== e.strb || wdata !== e.data) begin
                    n_bad++;
                    $display("FAIL write: got addr=%h strb=%h data=%h expected addr=%h strb=%h data=%h",
                             waddr, wstrb, wdata, e.addr, e.strb, e.data);
                end
            end
        end
    end

    task automatic send(input logic [AW-1:0] a, input logic [31:0] d, input logic l, output int acc);
        vld  = 1'b1;
        addr = a;
        data = d;
        last = l;
        acc  = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rdy) begin
                acc = cyc;
                break;
            end
            @(posedge clk);
            #1;
            if (rand_mode) atom = ($urandom_range(0, 3) != 0);
        end
        if (acc < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_accept: got no accept for addr=%h, expected accept", a);
        end
        @(posedge clk);
        #1;
        vld = 1'b0;
    endtask

    task automatic wait_we(output int c);
        c = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (we) begin
                c = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (idle && exp_q.size() == 0 && !we) begin
                ok = 1;
                break;
            end
        end
        chk_int(name, ok, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, a0, c, we0, ok;
        logic [8:0] ln;
        rst_n = 1'b0;
        vld   = 1'b0;
        addr  = '0;
        data  = '0;
        last  = 1'b0;
        atom  = 1'b1;
        repeat (2) @(negedge clk);
        chk_int("rst_we", int'(we), 0);
        chk_int("rst_waddr", int'(waddr), 0);
        chk_int("rst_wdata_zero", int'(wdata == '0), 1);
        chk_int("rst_wstrb", int'(wstrb), 0);
        chk_int("rst_rdy", int'(rdy), 1);
        chk_int("rst_idle", int'(idle), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Full line, consecutive beats, last on word 7
        a0 = 0;
        for (int w = 0; w < 8; w++) begin
            send(14'h0400 + 14'(w * 4), 32'hA000_0000 + 32'(w), (w == 7), acc);
            if (w == 0) a0 = acc;
        end
        wait_we(c);
        chk_int("full_line_latency", c, a0 + 8);
        drain("drain_full_line");

        // Two partial lines in order
        send(14'h0048, 32'h1111_2222, 1'b0, acc);
        send(14'h0074, 32'h3333_4444, 1'b1, acc);
        drain("drain_two_lines");

        // Timeout flush of a single beat
        send(14'h0100, 32'hDEAD_BEEF, 1'b0, acc);
        wait_we(c);
        chk_int("tmo_latency", c, acc + 16);
        drain("drain_tmo");

        // last-beat latency with pending empty
        send(14'h0208, 32'hCAFE_0001, 1'b1, acc);
        wait_we(c);
        chk_int("last_latency", c, acc + 1);
        drain("drain_last");

        // Atomic lock: three lines, third stalls until release
        atom = 1'b0;
        send(14'h1000, 32'h0000_000A, 1'b0, acc);
        send(14'h2004, 32'h0000_000B, 1'b0, acc);
        we0  = we_cnt;
        vld  = 1'b1;
        addr = 14'h3008;
        data = 32'h0000_000C;
        last = 1'b0;
        ok   = 1;
        repeat (20) begin
            @(negedge clk);
            if (rdy) ok = 0;
        end
        chk_int("atom_rdy_low", ok, 1);
        chk_int("atom_no_we", we_cnt, we0);
        @(posedge clk);
        #1;
        atom = 1'b1;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rdy) begin
                ok = 1;
                break;
            end
        end
        chk_int("atom_rdy_recover", ok, 1);
        @(posedge clk);
        #1;
        vld = 1'b0;
        drain("drain_atom");

        // Repeated word: last beat wins
        send(14'h050C, 32'hAAAA_AAAA, 1'b0, acc);
        send(14'h050C, 32'hBBBB_BBBB, 1'b1, acc);
        drain("drain_overwrite");

        // Reset while a line waits on the lock
        atom = 1'b0;
        send(14'h0610, 32'h5555_6666, 1'b1, acc);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk_int("midrst_idle", int'(idle), 1);
        chk_int("midrst_rdy", int'(rdy), 1);
        chk_int("midrst_we", int'(we), 0);
        we0 = we_cnt;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        atom  = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk_int("midrst_no_we", we_cnt, we0);

        // Randomized traffic with random lock and idle gaps
        rand_mode = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 20)) begin
                    atom = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
            end
            atom = ($urandom_range(0, 3) != 0);
            ln = 9'($urandom_range(0, 3) * 37 + 5);
            send({ln, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))}, $urandom,
                 ($urandom_range(0, 7) == 0), acc);
        end
        rand_mode = 1'b0;
        atom = 1'b1;
        drain("drain_random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hpu_dtcm_wr_pack.md
# hpu_dtcm_wr_pack

Write-coalescing stage directly upstream of the DTCM NDMA/lcarb write port. Accepts 32-bit NDMA write beats, merges them into 256-bit line images with per-word strobes in a two-slot (fill/pending) buffer, and issues full-line writes (`mem_we`/`waddr`/`wdata`/`wstrb[7:0]`). Each line write is held back while the DTCM atomic bus lock is active (`mem_atom_ready` low).

## Interface
Reset is asynchronous and active-low on `rst_i`; single clock `clk_i`.

Parameters:
- FLUSH_TMO, 16 — idle cycles before a partial fill line is sealed; 0 disables the timeout.
- ADDR_W, 14 — DTCM byte-address width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-low reset
- ndma_pack__beat_vld_i  in  1  beat valid
- ndma_pack__beat_addr_i  in  ADDR_W  byte address; [1:0] ignored
- ndma_pack__beat_data_i  in  32  beat data
- ndma_pack__beat_last_i  in  1  seal line after this beat
- pack_ndma__beat_rdy_o  out  1  beat accepted when vld&rdy
- pack_dtcm__mem_we_o  out  1  one-cycle line write strobe
- pack_dtcm__mem_waddr_o  out  ADDR_W  {line, 5'b0}
- pack_dtcm__mem_wdata_o  out  256  line image
- pack_dtcm__mem_wstrb_o  out  8  one bit per 32-bit word
- dtcm_pack__mem_atom_ready_i  in  1  DTCM not bus-locked
- pack_ndma__idle_o  out  1  both slots empty

## Operation
- State per slot: vld, line[8:0] (= addr[13:5]), data[255:0], strb[7:0]. The fill slot also has a seal flag; the pending slot is always older than the fill slot.
- Beat word index = addr[4:2]. Merge writes data[idx*32 +: 32] and sets strb[idx]. A repeated word overwrites (last beat wins).
- Beat routing on accept:
  - Fill empty → open the fill slot with the beat's line.
  - Fill valid, unsealed, same line → merge into the fill slot.
  - Otherwise → promote fill to pending, and open a new fill with the beat in the same cycle.
- Seal conditions, evaluated after merge: strb == 8'hFF, beat_last, or timeout.
- Promotion of fill to pending:
  - Occurs when fill is sealed, or when a mismatching beat arrives.
  - Requires pending empty, or pending issuing in the same cycle.
- Issue: `mem_we_o = pend_vld & dtcm_pack__mem_atom_ready_i`. `waddr`/`wdata`/`wstrb` are driven from the pending slot; pending clears at the next edge.
- `beat_rdy_o` is low only when a beat would need promotion (fill valid and sealed or line mismatch), pending is valid, and pending is not issuing this cycle.
- Timeout counter:
  - Clears on any accepted beat and whenever fill is empty.
  - Increments while fill is valid, unsealed and idle.
  - Reaching FLUSH_TMO-1 seals the fill slot.
- DTCM writes occur strictly in beat-acceptance line order. No reads, no address checking; out-of-range lines are passed through.
- `idle_o = !fill_vld & !pend_vld`.

## Timing
- Reset values: mem_we 0, waddr 0, wdata 0, wstrb 0, beat_rdy 1, idle 1; all slots invalid, counter 0.
- Reset mid-operation: buffered data is discarded with no write; outputs take reset values immediately (async).
- Latency, last beat accepted in cycle N with pending empty and atom_ready=1: promotion at edge N+1, mem_we high during cycle N+1.
- Eight same-line beats in consecutive cycles N..N+7 → a single write in cycle N+8 with wstrb=8'hFF.
- atom_ready low: pending holds, mem_we stays 0. The fill slot keeps merging until it needs promotion, then rdy drops. The write issues in the first cycle atom_ready returns high.
- Simultaneous pending issue and mismatching beat: the beat is accepted (rdy=1); the old fill moves to pending at the same edge.
- Simultaneous seal and mismatching beat in the same cycle: treated as a single promotion.
- Timeout sealing does not interrupt a back-to-back beat stream.

## Structure
- Add to hpu_pkg:
  - `LINE_W=256`, `LINE_WORDS=8`
  - `PACK_FLUSH_TMO=16`
  - typedef `dtcm_line_slot_t` (vld, line, data, strb)
- Optional sub-module `hpu_dtcm_line_merge`: combinational word insert plus full detect, instantiated for the fill slot. Everything else lives in one module.

## Test plan
- Beats to words 0..7 of addr 14'h0400, last on word 7 → one write, waddr 14'h0400, wstrb 8'hFF, words ordered by index.
- Beats to word 2 of 14'h0040 then word 5 of 14'h0060 → two writes, wstrb 8'h04 then 8'h20, in that order.
- Single beat, no last, FLUSH_TMO=16 → write issued exactly 16 cycles after acceptance, wstrb 8'h01.
- atom_ready held low for 20 cycles with three distinct lines sent:
  - rdy drops after the second mismatch; mem_we stays 0.
  - On release, writes are issued in order and rdy recovers.
- Two beats to the same word (data A then B) → write contains B.
- rst_i asserted while pending is valid and atom_ready=0 → no mem_we ever issued for that data; idle=1 and rdy=1 after reset.
